rom_burst_arbiter: RTL
======================

ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of ROM word and output data.
REQ-002 Parameter ADDR_WIDTH, default 3, ROM address width; ROM depth 2**ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester burst request, level, held until granted.
REQ-006 start_addr0, start_addr1  input  ADDR_WIDTH each  first ROM address of burst.
REQ-007 len0, len1  input  ADDR_WIDTH each  burst length minus one (1..2**ADDR_WIDTH beats).
REQ-008 gnt  output  2  one-hot, one-cycle grant pulse.
REQ-009 rom_addr  output  ADDR_WIDTH  address to the asynchronous ROM.
REQ-010 rom_q  input  DATA_WIDTH  combinational ROM read data.
REQ-011 out_data  output  DATA_WIDTH  registered burst beat.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  consumer accepts beat when out_valid and out_ready both high at an edge.
REQ-014 out_id  output  1  requester index owning current beat.
REQ-015 out_last  output  1  high with final beat of burst.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, BURST, DRAIN.
REQ-018 IDLE: if req nonzero, select winner, pulse gnt[winner] for that cycle, latch winner's start_addr/len and id, go BURST; else stay IDLE.
REQ-019 Arbitration round-robin: single request wins; both requesting -> requester other than last_served wins; last_served updates at grant.
REQ-020 rom_addr driven from registered cur_addr; cur_addr = latched start at BURST entry; rom_addr = 0 in IDLE.
REQ-021 BURST: beat advance when out_valid==0 or out_ready==1; on advance out_data<=rom_q, out_valid<=1, out_id<=owner, cur_addr<=cur_addr+1 modulo 2**ADDR_WIDTH, remaining count decrements.
REQ-022 No advance (out_valid=1, out_ready=0): out_data, out_valid, cur_addr, count all held.
REQ-023 Advance loading final beat sets out_last=1 and moves to DRAIN.
REQ-024 DRAIN: when out_valid and out_ready, clear out_valid and out_last, go IDLE; else hold.
REQ-025 BURST with out_ready=0 and out_valid=0 still loads a beat (empty register accepts).
REQ-026 Latency: gnt in cycle T; first beat valid from cycle T+2; with out_ready constantly 1, one beat per cycle.
REQ-027 Minimum one IDLE cycle between bursts; req sampled only in IDLE; req changes during BURST/DRAIN ignored.
REQ-028 len=0 gives single beat, out_last on that beat; len=2**ADDR_WIDTH-1 reads all entries, wrapping.
REQ-029 req withdrawn before grant: no grant, no state change.

Reset
REQ-030 reset_n low asynchronously forces IDLE, gnt=0, out_valid=0, out_last=0, out_id=0, out_data=0, rom_addr=0, busy=0, last_served=1 (requester 0 wins first tie).
REQ-031 Reset mid-burst discards burst; no beat emitted; after release arbitration restarts from IDLE.

Verification (ROM model: addr 0..7 returns ED,B7,18,E7,CC,0F,F0,AA)
REQ-032 req=01, start_addr0=6, len0=3, out_ready=1 -> gnt=01 one cycle; beats F0,AA,ED,B7 consecutive, out_id=0, out_last on B7 only.
REQ-033 After reset req=11 held -> gnt0 first; req0 dropped after its burst, req1 held -> gnt1 next; then req=11 again -> gnt0.
REQ-034 Burst start=2 len=3; out_ready low 3 cycles after first beat -> out_data stays 18, rom_addr stays 3; release yields E7,CC,0F, none lost or duplicated.
REQ-035 start_addr1=4, len1=0 -> single beat CC with out_last=1, out_id=1; busy low one cycle after acceptance.
REQ-036 reset_n pulsed low during second beat of 8-beat burst -> out_valid, gnt, busy low immediately; after release with req=10, gnt=10 within one cycle, burst from start_addr1.

Source files
------------

// File: rtl/rom_burst_arbiter_if.sv
// Bundles the requester, ROM and beat-output signals of the ROM burst arbiter.
// The master side is the surrounding system; the slave side is the arbiter.
interface rom_burst_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [1:0]            req;
  logic [ADDR_WIDTH-1:0] start_addr0;
  logic [ADDR_WIDTH-1:0] start_addr1;
  logic [ADDR_WIDTH-1:0] len0;
  logic [ADDR_WIDTH-1:0] len1;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_id;
  logic                  out_last;
  logic                  busy;

  modport master (
    output req, start_addr0, start_addr1, len0, len1, rom_q, out_ready,
    input  gnt, rom_addr, out_data, out_valid, out_id, out_last, busy
  );

  modport slave (
    input  req, start_addr0, start_addr1, len0, len1, rom_q, out_ready,
    output gnt, rom_addr, out_data, out_valid, out_id, out_last, busy
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter between two requesters that streams a wrapping burst of
// words from an asynchronous ROM into a single registered valid/ready output.
module rom_burst_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic                clk,
  input logic                reset_n,
  rom_burst_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  out_id_q, out_id_d;
  logic                  owner_q, owner_d;
  logic                  last_served_q, last_served_d;
  logic [1:0]            gnt_c;
  logic                  winner;
  logic                  advance;

  // On a tie the requester that was not served last wins.
  assign winner  = bus.req[1] & (~bus.req[0] | ~last_served_q);
  assign advance = ~out_valid_q | bus.out_ready;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_id_d      = out_id_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    gnt_c         = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_c         = winner ? 2'b10 : 2'b01;
          owner_d       = winner;
          last_served_d = winner;
          cur_addr_d    = winner ? bus.start_addr1 : bus.start_addr0;
          remaining_d   = winner ? bus.len1 : bus.len0;
          state_d       = BURST;
        end
      end
      BURST: begin
        if (advance) begin
          out_data_d  = bus.rom_q;
          out_valid_d = 1'b1;
          out_id_d    = owner_q;
          cur_addr_d  = cur_addr_q + 1'b1;
          // A zero remaining count means the word being loaded closes the burst.
          if (remaining_q == '0) begin
            out_last_d = 1'b1;
            state_d    = DRAIN;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_id_q      <= 1'b0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_id_q      <= out_id_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
    end
  end

  // The grant is combinational so the burst start address is loaded at the grant edge.
  assign bus.gnt       = reset_n ? gnt_c : 2'b00;
  assign bus.rom_addr  = (state_q == IDLE) ? '0 : cur_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
